int_ctrl_multi: RTL and testbench
=================================

INT_CTRL_MULTI -- requirements
Module: int_ctrl_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of interrupt channels (1..8).
REQ-002 SHALL have parameter REG_BASE, default 8'h09, LPC address of STATUS; ENABLE=REG_BASE+1, MODE=REG_BASE+2, POL=REG_BASE+3.
REQ-003 SHALL have parameter REARM_CYCLES, default 4, minimum IRQ-deasserted gap in clocks (1..15).
REQ-004 SHALL have ports: Clk in 1 system clock; ResetN in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: Wr in 1 LPC write strobe; Addr in 8 register address; DataWr in 8 write data.
REQ-006 SHALL have ports: IntSrc in NUM_CH asynchronous interrupt sources; DataRd out 8 read data; Pending out NUM_CH masked pending vector; InterruptD out 1 open-drain IRQ to CPU (drives 0 or z).

Function
REQ-007 SHALL pass each IntSrc bit through a 2-flop synchronizer, then XOR with POL bit (1 = active-low source) to form the active-high event level.
REQ-008 SHALL, per channel, set STATUS bit on rising edge of the event level when MODE bit=1 (edge), or every cycle the event level is high when MODE bit=0 (level).
REQ-009 SHALL clear a STATUS bit when Wr and Addr==REG_BASE and DataWr bit=1 (write-1-to-clear); DataWr bit=0 leaves the bit unchanged.
REQ-010 SHALL give set priority over clear when both occur for the same bit in the same cycle.
REQ-011 SHALL write ENABLE, MODE, POL registers fully on Wr with matching Addr; bits at or above NUM_CH ignored and read 0.
REQ-012 SHALL drive DataRd combinationally: register contents for the four addresses, zero-extended to 8 bits; 8'h00 for any other address.
REQ-013 SHALL drive Pending = STATUS & ENABLE, combinational from registered state.
REQ-014 SHALL implement IRQ FSM with states IDLE, ASSERT, REARM; InterruptD=0 only in ASSERT, z otherwise.
REQ-015 SHALL transition IDLE->ASSERT when |Pending; ASSERT->REARM when Pending==0; REARM->IDLE after REARM_CYCLES clocks; REARM ignores Pending until expiry.
REQ-016 SHALL, if Pending is nonzero on REARM expiry, go REARM->ASSERT directly (guaranteed high gap of exactly REARM_CYCLES clocks).
REQ-017 SHALL make latency IntSrc edge to InterruptD low = 4 clocks (2 sync, 1 STATUS, 1 FSM) when enabled and FSM in IDLE.
REQ-018 SHALL, on ENABLE write clearing the last pending bit while in ASSERT, move to REARM next clock; STATUS bits are retained.
REQ-019 SHALL update the edge detector history every clock regardless of MODE, so a MODE change never manufactures an edge.

Reset
REQ-020 SHALL, on ResetN low (asynchronous), clear STATUS, ENABLE, MODE, POL, synchronizers, edge history, REARM counter to 0 and FSM to IDLE.
REQ-021 SHALL hold DataRd=8'h00 (for REG_BASE addresses), Pending=0, InterruptD=z during and immediately after reset.
REQ-022 SHALL not capture any event on the first clock after ResetN deasserts, since synchronizer history is 0 (POL=0 at reset).

Structure
REQ-023 SHALL place register offsets (STATUS=0, ENABLE=1, MODE=2, POL=3) and FSM state encoding in a shared package int_ctrl_pkg.
REQ-024 SHALL use one sub-module int_ch_detect (synchronizer, polarity, edge/level detect, sticky STATUS bit), instantiated NUM_CH times.

Verification
REQ-025 Edge: ENABLE=4'h1, MODE=4'h1, pulse IntSrc[0] high 1 clock -> STATUS=4'h1, InterruptD low 4 clocks later; write 8'h01 to REG_BASE -> InterruptD z next clock, then REARM_CYCLES gap.
REQ-026 Level: MODE=0, ENABLE=4'h2, IntSrc[1] held high, W1C 8'h02 -> STATUS[1] stays 1, InterruptD stays low; release IntSrc[1], W1C -> cleared.
REQ-027 Simultaneous: W1C of bit 2 in the same cycle a new edge sets bit 2 -> STATUS[2] remains 1.
REQ-028 Rearm: two channels pending, clear first then second back-to-back, new event during REARM -> InterruptD high exactly 4 clocks, then low again.
REQ-029 Polarity/mask: POL=4'h8, IntSrc[3] falls, ENABLE=0 -> STATUS[3]=1, Pending=0, InterruptD z; write ENABLE=4'h8 -> low 2 clocks later.
REQ-030 Reset mid-ASSERT: ResetN low -> InterruptD z immediately, all registers read 8'h00; read of Addr 8'h20 -> 8'h00.

Source files
------------

// File: rtl/int_ctrl_pkg.sv
// ============================================================================
// Module : int_ctrl_pkg
// Brief  : Shared register offsets and IRQ state encoding for int_ctrl_multi.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package int_ctrl_pkg;

    localparam logic [7:0] OFF_STATUS = 8'd0;
    localparam logic [7:0] OFF_ENABLE = 8'd1;
    localparam logic [7:0] OFF_MODE   = 8'd2;
    localparam logic [7:0] OFF_POL    = 8'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_REARM  = 2'd2
    } irq_state_e;

endpackage

`default_nettype wire

// File: rtl/int_ch_detect.sv
// ============================================================================
// Module : int_ch_detect
// Brief  : One interrupt channel: 2-flop sync, polarity, edge/level detect,
//          sticky write-1-to-clear STATUS bit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_ch_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_src,
    input  logic i_pol,
    input  logic i_mode,
    input  logic i_clr,
    output logic o_status
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic hist_q, hist_d;
    logic status_q, status_d;
    logic event_lvl;
    logic set_evt;

    always_comb begin
        sync1_d   = i_src;
        sync2_d   = sync1_q;
        event_lvl = sync2_q ^ i_pol;
        // History tracks the event level in both modes so a MODE flip sees no edge.
        hist_d    = event_lvl;
        set_evt   = i_mode ? (event_lvl & ~hist_q) : event_lvl;
        status_d  = set_evt | (status_q & ~i_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            hist_q   <= hist_d;
            status_q <= status_d;
        end
    end

    assign o_status = status_q;

endmodule

`default_nettype wire

// File: rtl/int_ctrl_multi.sv
// ============================================================================
// Module : int_ctrl_multi
// Brief  : Multi-channel LPC interrupt controller with open-drain IRQ output
//          and a guaranteed deassert gap between IRQ pulses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module int_ctrl_multi
    import int_ctrl_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter logic [7:0] REG_BASE     = 8'h09,
    parameter int         REARM_CYCLES = 4
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              Wr,
    input  logic [7:0]        Addr,
    input  logic [7:0]        DataWr,
    input  logic [NUM_CH-1:0] IntSrc,
    output logic [7:0]        DataRd,
    output logic [NUM_CH-1:0] Pending,
    output wire               InterruptD
);

    localparam logic [7:0] ADDR_STATUS = REG_BASE + OFF_STATUS;
    localparam logic [7:0] ADDR_ENABLE = REG_BASE + OFF_ENABLE;
    localparam logic [7:0] ADDR_MODE   = REG_BASE + OFF_MODE;
    localparam logic [7:0] ADDR_POL    = REG_BASE + OFF_POL;
    localparam logic [3:0] REARM_LOAD  = 4'(REARM_CYCLES - 1);

    logic [NUM_CH-1:0] status;
    logic [NUM_CH-1:0] enable_q, enable_d;
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] pol_q, pol_d;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] wdata;
    logic [NUM_CH-1:0] pending;
    logic [7:0]        rd_data;
    irq_state_e        state_q;
    logic [3:0]        rearm_cnt_q;
    logic              unused_data;

    // Upper write-data bits are meaningless for narrower configurations.
    assign unused_data = ^DataWr;
    assign wdata       = DataWr[NUM_CH-1:0];

    always_comb begin
        enable_d = enable_q;
        mode_d   = mode_q;
        pol_d    = pol_q;
        clr      = '0;
        if (Wr) begin
            case (Addr)
                ADDR_STATUS: clr      = wdata;
                ADDR_ENABLE: enable_d = wdata;
                ADDR_MODE:   mode_d   = wdata;
                ADDR_POL:    pol_d    = wdata;
                default:     ;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            enable_q <= '0;
            mode_q   <= '0;
            pol_q    <= '0;
        end else begin
            enable_q <= enable_d;
            mode_q   <= mode_d;
            pol_q    <= pol_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        int_ch_detect u_det (
            .clk      (Clk),
            .rst_n    (ResetN),
            .i_src    (IntSrc[i]),
            .i_pol    (pol_q[i]),
            .i_mode   (mode_q[i]),
            .i_clr    (clr[i]),
            .o_status (status[i])
        );
    end

    assign pending = status & enable_q;
    assign Pending = pending;

    always_comb begin
        rd_data = 8'h00;
        case (Addr)
            ADDR_STATUS: rd_data[NUM_CH-1:0] = status;
            ADDR_ENABLE: rd_data[NUM_CH-1:0] = enable_q;
            ADDR_MODE:   rd_data[NUM_CH-1:0] = mode_q;
            ADDR_POL:    rd_data[NUM_CH-1:0] = pol_q;
            default:     ;
        endcase
    end
    assign DataRd = rd_data;

    // REARM holds the line released for exactly REARM_CYCLES clocks, pending or not.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= ST_IDLE;
            rearm_cnt_q <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|pending) state_q <= ST_ASSERT;
                end
                ST_ASSERT: begin
                    if (pending == '0) begin
                        state_q     <= ST_REARM;
                        rearm_cnt_q <= REARM_LOAD;
                    end
                end
                ST_REARM: begin
                    if (rearm_cnt_q == 4'd0) begin
                        state_q <= (|pending) ? ST_ASSERT : ST_IDLE;
                    end else begin
                        rearm_cnt_q <= rearm_cnt_q - 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign InterruptD = (state_q == ST_ASSERT) ? 1'b0 : 1'bz;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl_multi.sv
// ============================================================================
// Module : tb_int_ctrl_multi
// Brief  : Self-checking bench for int_ctrl_multi (default parameters).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_int_ctrl_multi;

    localparam int         R    = 4;
    localparam logic [7:0] A_ST = 8'h09;
    localparam logic [7:0] A_EN = 8'h0A;
    localparam logic [7:0] A_MD = 8'h0B;
    localparam logic [7:0] A_PL = 8'h0C;

    logic       Clk = 1'b0;
    logic       ResetN = 1'b0;
    logic       Wr = 1'b0;
    logic [7:0] Addr = 8'h00;
    logic [7:0] DataWr = 8'h00;
    logic [3:0] IntSrc = 4'h0;
    wire  [7:0] DataRd;
    wire  [3:0] Pending;
    wire        irq_line;

    // Board-level pull-up on the open-drain IRQ: released line reads 1.
    pullup (irq_line);

    int_ctrl_multi #(.NUM_CH(4), .REG_BASE(8'h09), .REARM_CYCLES(R)) dut (
        .Clk        (Clk),
        .ResetN     (ResetN),
        .Wr         (Wr),
        .Addr       (Addr),
        .DataWr     (DataWr),
        .IntSrc     (IntSrc),
        .DataRd     (DataRd),
        .Pending    (Pending),
        .InterruptD (irq_line)
    );

    always #5 Clk = ~Clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %02h expected %02h", nm, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [3:0] m_status, m_en, m_mode, m_pol, m_prev_ev, m_pend_prev;
    logic [3:0] m_smp[$];
    bit         m_asserted;
    int         m_cyc, m_quiet_until;

    task automatic model_reset();
        m_status = 0; m_en = 0; m_mode = 0; m_pol = 0; m_prev_ev = 0; m_pend_prev = 0;
        m_smp = '{4'h0, 4'h0};
        m_asserted = 0; m_cyc = 0; m_quiet_until = 0;
    endtask

    function automatic logic [7:0] m_read(input logic [7:0] a);
        case (a)
            A_ST:    return {4'h0, m_status};
            A_EN:    return {4'h0, m_en};
            A_MD:    return {4'h0, m_mode};
            A_PL:    return {4'h0, m_pol};
            default: return 8'h00;
        endcase
    endfunction

    // Event level seen at an edge is the source sampled two edges earlier, XOR POL.
    // IRQ rule: once released at edge e, the line may not drop again before edge e+R.
    task automatic model_edge();
        logic [3:0] ev, setv, clr;
        ev   = m_smp[0] ^ m_pol;
        setv = (m_mode & ev & ~m_prev_ev) | (~m_mode & ev);
        clr  = (Wr && Addr == A_ST) ? DataWr[3:0] : 4'h0;
        if (m_asserted) begin
            if (m_pend_prev == 4'h0) begin
                m_asserted    = 0;
                m_quiet_until = m_cyc + R;
            end
        end else if (m_cyc >= m_quiet_until && m_pend_prev != 4'h0) begin
            m_asserted = 1;
        end
        if (Wr && Addr == A_EN) m_en   = DataWr[3:0];
        if (Wr && Addr == A_MD) m_mode = DataWr[3:0];
        if (Wr && Addr == A_PL) m_pol  = DataWr[3:0];
        m_status    = setv | (m_status & ~clr);
        m_pend_prev = m_status & m_en;
        m_prev_ev   = ev;
        m_smp.push_back(IntSrc);
        void'(m_smp.pop_front());
        m_cyc++;
    endtask

    task automatic cycle();
        model_edge();
        @(posedge Clk);
        #1;
        check("pending", 8'(Pending), 8'(m_status & m_en));
        check("irq", 8'(irq_line), m_asserted ? 8'h00 : 8'h01);
        check("rdata", DataRd, m_read(Addr));
    endtask

    task automatic wreg(input logic [7:0] a, input logic [7:0] d);
        Wr = 1'b1; Addr = a; DataWr = d;
        cycle();
        Wr = 1'b0; DataWr = 8'h00;
    endtask

    task automatic peek(input logic [7:0] a, output logic [7:0] d);
        Addr = a;
        #1;
        d = DataRd;
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       do_wr;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [7:0] d;

        vecs[0] = '{A_EN,  8'hFF, 1'b1, 8'h0F};
        vecs[1] = '{A_MD,  8'h35, 1'b1, 8'h05};
        vecs[2] = '{A_PL,  8'hA0, 1'b1, 8'h00};
        vecs[3] = '{8'h0D, 8'h00, 1'b0, 8'h00};
        vecs[4] = '{8'h0D, 8'hFF, 1'b1, 8'h00};
        vecs[5] = '{A_EN,  8'h00, 1'b0, 8'h0F};
        vecs[6] = '{8'h08, 8'h00, 1'b0, 8'h00};
        vecs[7] = '{A_ST,  8'hFF, 1'b1, 8'h00};
        vecs[8] = '{A_EN,  8'h00, 1'b1, 8'h00};
        vecs[9] = '{A_MD,  8'h00, 1'b0, 8'h05};

        // reset state
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        check("rst_pending", 8'(Pending), 8'h00);
        check("rst_irq", 8'(irq_line), 8'h01);
        for (int a = 9; a <= 12; a++) begin
            peek(8'(a), d);
            check("rst_reg", d, 8'h00);
        end
        ResetN = 1'b1;

        // no capture on the first clock after reset, even with all sources high
        IntSrc = 4'hF;
        Addr = A_ST;
        cycle();
        check("first_clk", DataRd, 8'h00);
        cycle(); cycle();
        check("lvl_after_sync", DataRd, 8'h0F);
        IntSrc = 4'h0;
        repeat (3) cycle();
        wreg(A_ST, 8'hFF);
        check("w1c_all", DataRd, 8'h00);

        // register table
        for (int i = 0; i < 10; i++) begin
            Addr = vecs[i].addr; Wr = vecs[i].do_wr; DataWr = vecs[i].wdata;
            cycle();
            Wr = 1'b0; DataWr = 8'h00;
            check($sformatf("tbl_rd[%0d]", i), DataRd, vecs[i].exp_rd);
        end

        // edge mode, 4-clock latency, W1C release and gap
        wreg(A_MD, 8'h01); wreg(A_EN, 8'h01);
        IntSrc = 4'h1; cycle(); IntSrc = 4'h0; cycle(); cycle();
        check("edge_lat3", 8'(irq_line), 8'h01);
        peek(A_ST, d);
        check("edge_status", d, 8'h01);
        cycle();
        check("edge_lat4", 8'(irq_line), 8'h00);
        wreg(A_ST, 8'h01);
        check("w1c_hold", 8'(irq_line), 8'h00);
        check("w1c_pend", 8'(Pending), 8'h00);
        cycle();
        check("w1c_release", 8'(irq_line), 8'h01);
        repeat (4) cycle();

        // level mode: W1C while source active does not clear
        wreg(A_MD, 8'h00); wreg(A_EN, 8'h02);
        IntSrc = 4'h2; repeat (4) cycle();
        check("lvl_assert", 8'(irq_line), 8'h00);
        wreg(A_ST, 8'h02);
        check("lvl_sticky", 8'(Pending), 8'h02);
        check("lvl_irq_hold", 8'(irq_line), 8'h00);
        IntSrc = 4'h0; repeat (3) cycle();
        wreg(A_ST, 8'h02);
        check("lvl_cleared", 8'(Pending), 8'h00);
        repeat (6) cycle();

        // set wins over simultaneous clear
        wreg(A_EN, 8'h00); wreg(A_MD, 8'h04);
        IntSrc = 4'h4; cycle(); IntSrc = 4'h0; cycle();
        wreg(A_ST, 8'h04);
        peek(A_ST, d);
        check("simul_set_wins", d, 8'h04);
        wreg(A_ST, 8'h04);
        peek(A_ST, d);
        check("simul_clear", d, 8'h00);

        // rearm gap with event arriving during REARM
        wreg(A_MD, 8'h03); wreg(A_EN, 8'h03);
        IntSrc = 4'h3; cycle(); IntSrc = 4'h0; repeat (3) cycle();
        check("rearm_assert", 8'(irq_line), 8'h00);
        wreg(A_ST, 8'h01);
        check("rearm_first", 8'(irq_line), 8'h00);
        wreg(A_ST, 8'h02);
        IntSrc = 4'h1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            IntSrc = 4'h0;
            check($sformatf("rearm_gap[%0d]", i), 8'(irq_line), 8'h01);
        end
        cycle();
        check("rearm_reassert", 8'(irq_line), 8'h00);
        wreg(A_ST, 8'h01);
        repeat (6) cycle();

        // polarity and mask
        wreg(A_EN, 8'h00); wreg(A_MD, 8'h00);
        IntSrc = 4'h8; repeat (3) cycle();
        wreg(A_PL, 8'h08);
        wreg(A_ST, 8'h08);
        peek(A_ST, d);
        check("pol_clear", d, 8'h00);
        IntSrc = 4'h0; repeat (3) cycle();
        peek(A_ST, d);
        check("pol_status", d, 8'h08);
        check("pol_masked", 8'(Pending), 8'h00);
        check("pol_irq_z", 8'(irq_line), 8'h01);
        wreg(A_EN, 8'h08);
        check("pol_en_1", 8'(irq_line), 8'h01);
        check("pol_en_pend", 8'(Pending), 8'h08);
        cycle();
        check("pol_en_2", 8'(irq_line), 8'h00);

        // asynchronous reset while asserted
        ResetN = 1'b0;
        #1;
        check("arst_irq", 8'(irq_line), 8'h01);
        check("arst_pending", 8'(Pending), 8'h00);
        for (int a = 9; a <= 12; a++) begin
            peek(8'(a), d);
            check("arst_reg", d, 8'h00);
        end
        peek(8'h20, d);
        check("arst_other", d, 8'h00);
        model_reset();
        IntSrc = 4'h0;
        @(posedge Clk);
        #1;
        ResetN = 1'b1;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            IntSrc = 4'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                Wr = 1'b1;
                Addr = 8'(9 + $urandom_range(0, 4));
                DataWr = 8'($urandom);
            end else begin
                Addr = ($urandom_range(0, 5) == 0) ? 8'h20 : 8'(9 + $urandom_range(0, 3));
            end
            cycle();
            Wr = 1'b0; DataWr = 8'h00;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
